datapath_ctrl: RTL and testbench
================================

# datapath_ctrl

Multi-cycle Moore sequencer that accepts one 16-bit instruction at a time and drives every control input of the register-file/shifter/ALU `datapath` to execute it. It sits between an instruction source (switch interface or future fetch unit) and `datapath`, replacing manual per-stage switch control. It also keeps a retired-instruction count and flags illegal encodings.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces IDLE
- start  in  1  request; sampled only in IDLE
- instr  in  16  instruction; latched when start accepted
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse in state DONE
- err  out  1  sticky illegal-opcode flag; cleared by next accepted start
- icount  out  8  retired-instruction counter, wraps 255→0
- readnum, writenum  out  3  register selects
- loada, loadb, loadc, loads, write, vsel, asel, bsel  out  1 each  datapath strobes/selects
- shift, ALUop  out  2 each  shifter / ALU op
- datapath_in  out  16  sign-extended immediate

## Operation
- Encoding: opcode=instr[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0], imm8=[7:0].
- Legal: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{sh}; 101/00 ADD Rd,Rn,Rm{sh}; 101/01 CMP Rn,Rm{sh}; 101/10 AND Rd,Rn,Rm{sh}; 101/11 MVN Rd,Rm{sh}. Anything else is illegal.
- States: IDLE, LOADA, LOADB, EXEC, WRITE, WRIMM, DONE.
- IDLE & start: latch instr, clear err. MOV-imm→WRIMM; MOV/MVN→LOADB; ADD/CMP/AND→LOADA; illegal→DONE with err set.
- LOADA→LOADB→EXEC; EXEC→WRITE, except CMP→DONE; WRITE→DONE; WRIMM→DONE; DONE→IDLE.
- Per-state outputs (all unlisted outputs are 0):
  - LOADA: readnum=Rn, loada=1.
  - LOADB: readnum=Rm, loadb=1.
  - EXEC: shift=sh, ALUop=op, loadc=1. MOV uses ALUop=00 with asel=1. MVN sets asel=1. CMP sets loads=1 and loadc=0.
  - WRITE: writenum=Rd, write=1, vsel=0.
  - WRIMM: writenum=Rn, write=1, vsel=1, datapath_in={{8{imm8[7]}},imm8}.
  - DONE: done=1; icount increments if err=0.
- bsel is always 0 in this revision.
- datapath_in is 0 in every state except WRIMM.
- start outside IDLE, including during DONE, is ignored and not queued.
- instr changes after acceptance have no effect.

## Timing
- Reset: state=IDLE; every output 0, including icount, err and datapath_in. Reset mid-instruction abandons it: no write, no done, no icount change.
- Outputs are decoded purely from state plus latched instr. No output combinationally depends on start or instr.
- Cycle 0 is the edge that accepts start. Cycles to the done pulse, counted inclusive:
  - ADD/AND: LOADA 1, LOADB 2, EXEC 3, WRITE 4, DONE 5.
  - MOV/MVN: DONE at cycle 4.
  - CMP: DONE at cycle 4.
  - MOV-imm: DONE at cycle 2.
  - Illegal: DONE at cycle 1.
- Earliest next acceptance is the cycle after DONE, i.e. the first IDLE cycle.
- Register file writes occur on the clk edge closing WRITE/WRIMM. Status updates on the edge closing CMP's EXEC.
- icount and err change on the edge leaving DONE / accepting start respectively.

## Configuration
- DATAPATH_CTRL_STEP_EN defined:
  - Adds input port step (1 bit).
  - Every non-IDLE state holds, with outputs unchanged, until a cycle with step=1, then transitions.
  - IDLE acceptance ignores step.
  - Strobes (load*, write) stay asserted while holding. This is acceptable because they are idempotent on the datapath.
  - Used for KEY-driven single-stepping on the DE1-SoC.
- Undefined: no step port; the FSM advances every cycle as in Timing.

## Test plan
- Reset, then MOV R3,#-5 (instr=16'hD3FB): cycle 1 write=1, vsel=1, writenum=3, datapath_in=16'hFFFB; done at cycle 2; icount=1.
- ADD R2,R1,R0 with sh=01 (instr=16'hA148): readnum=1 & loada at c1, readnum=0 & loadb at c2, shift=01 ALUop=00 loadc at c3, writenum=2 write at c4, done at c5.
- CMP R1,R0 (16'hA900): loads=1 at c3, never write=1, done at c4, icount increments.
- Illegal instr=16'h0000: done at c1, err=1, icount unchanged, all strobes 0; next valid start clears err.
- start held high continuously with ADD: accepted on the edges at c0 and c6 only. Assert reset at c2 of the second instruction: all outputs 0 within the same cycle, icount=0, no write pulse.
- With DATAPATH_CTRL_STEP_EN, MOV R1,R2 (16'hC022): with step=0 for 3 cycles, FSM stays in LOADB with loadb=1 and readnum=2; it advances one state per step pulse.

Source files
------------

// File: rtl/datapath_ctrl_if.sv
// Handshake and datapath-control bundle between an instruction source and datapath_ctrl.
// The source drives start/instr; the sequencer drives status and every datapath strobe.
interface datapath_ctrl_if;
    logic        start;
    logic [15:0] instr;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  icount;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        vsel;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] datapath_in;

    modport master (
        output start, instr,
        input  busy, done, err, icount, readnum, writenum,
               loada, loadb, loadc, loads, write, vsel, asel, bsel,
               shift, ALUop, datapath_in
    );

    modport slave (
        input  start, instr,
        output busy, done, err, icount, readnum, writenum,
               loada, loadb, loadc, loads, write, vsel, asel, bsel,
               shift, ALUop, datapath_in
    );
endinterface

// File: rtl/datapath_ctrl.sv
// Moore sequencer that executes one 16-bit instruction on the register-file/shifter/ALU datapath.
// Optional `DATAPATH_CTRL_STEP_EN adds a step input that gates every non-IDLE transition.
module datapath_ctrl (
    input  logic           clk,
    input  logic           reset,
`ifdef DATAPATH_CTRL_STEP_EN
    input  logic           step,
`endif
    datapath_ctrl_if.slave ctrl
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOADA, S_LOADB, S_EXEC, S_WRITE, S_WRIMM, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        C_MOVI, C_MOV, C_ADD, C_CMP, C_AND, C_MVN, C_ILL
    } iclass_t;

    function automatic iclass_t decode(input logic [15:0] i);
        case ({i[15:13], i[12:11]})
            5'b110_10: decode = C_MOVI;
            5'b110_00: decode = C_MOV;
            5'b101_00: decode = C_ADD;
            5'b101_01: decode = C_CMP;
            5'b101_10: decode = C_AND;
            5'b101_11: decode = C_MVN;
            default:   decode = C_ILL;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [15:0] instr_q;
    logic        err_q;
    logic [7:0]  icount_q;
    logic        advance;
    logic        accept;
    iclass_t     cls_q;

`ifdef DATAPATH_CTRL_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    assign accept = (state_q == S_IDLE) && ctrl.start;
    assign cls_q  = decode(instr_q);

    // NOTE: state lives in always_ff with non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            err_q    <= 1'b0;
            icount_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q <= ctrl.instr;
                err_q   <= (decode(ctrl.instr) == C_ILL);
            end
            if (state_q == S_DONE && advance && !err_q)
                icount_q <= icount_q + 8'd1;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl.start) begin
                    case (decode(ctrl.instr))
                        C_MOVI:               state_d = S_WRIMM;
                        C_MOV, C_MVN:         state_d = S_LOADB;
                        C_ADD, C_CMP, C_AND:  state_d = S_LOADA;
                        default:              state_d = S_DONE;
                    endcase
                end
            end
            S_LOADA: if (advance) state_d = S_LOADB;
            S_LOADB: if (advance) state_d = S_EXEC;
            S_EXEC:  if (advance) state_d = (cls_q == C_CMP) ? S_DONE : S_WRITE;
            S_WRITE: if (advance) state_d = S_DONE;
            S_WRIMM: if (advance) state_d = S_DONE;
            S_DONE:  if (advance) state_d = S_IDLE;
            default:              state_d = S_IDLE;
        endcase
    end

    logic [2:0]  readnum_o, writenum_o;
    logic        loada_o, loadb_o, loadc_o, loads_o, write_o, vsel_o, asel_o;
    logic [1:0]  shift_o, aluop_o;
    logic [15:0] datapath_in_o;

    // Outputs come only from state_q and the latched instruction.
    always_comb begin
        readnum_o     = '0;
        writenum_o    = '0;
        loada_o       = 1'b0;
        loadb_o       = 1'b0;
        loadc_o       = 1'b0;
        loads_o       = 1'b0;
        write_o       = 1'b0;
        vsel_o        = 1'b0;
        asel_o        = 1'b0;
        shift_o       = '0;
        aluop_o       = '0;
        datapath_in_o = '0;
        case (state_q)
            S_LOADA: begin
                readnum_o = instr_q[10:8];
                loada_o   = 1'b1;
            end
            S_LOADB: begin
                readnum_o = instr_q[2:0];
                loadb_o   = 1'b1;
            end
            S_EXEC: begin
                shift_o = instr_q[4:3];
                aluop_o = instr_q[12:11];
                loadc_o = 1'b1;
                case (cls_q)
                    C_MOV: begin
                        aluop_o = 2'b00;
                        asel_o  = 1'b1;
                    end
                    C_MVN: asel_o = 1'b1;
                    C_CMP: begin
                        loads_o = 1'b1;
                        loadc_o = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_WRITE: begin
                writenum_o = instr_q[7:5];
                write_o    = 1'b1;
            end
            S_WRIMM: begin
                writenum_o    = instr_q[10:8];
                write_o       = 1'b1;
                vsel_o        = 1'b1;
                datapath_in_o = {{8{instr_q[7]}}, instr_q[7:0]};
            end
            default: ;
        endcase
    end

    assign ctrl.busy        = (state_q != S_IDLE);
    assign ctrl.done        = (state_q == S_DONE);
    assign ctrl.err         = err_q;
    assign ctrl.icount      = icount_q;
    assign ctrl.readnum     = readnum_o;
    assign ctrl.writenum    = writenum_o;
    assign ctrl.loada       = loada_o;
    assign ctrl.loadb       = loadb_o;
    assign ctrl.loadc       = loadc_o;
    assign ctrl.loads       = loads_o;
    assign ctrl.write       = write_o;
    assign ctrl.vsel        = vsel_o;
    assign ctrl.asel        = asel_o;
    assign ctrl.bsel        = 1'b0;
    assign ctrl.shift       = shift_o;
    assign ctrl.ALUop       = aluop_o;
    assign ctrl.datapath_in = datapath_in_o;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: the model expands each accepted instruction into its
// expected per-cycle control outputs; a negedge monitor pops and compares every cycle.
module tb_datapath_ctrl;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [7:0]  icount;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        write;
        logic        vsel;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  alu;
        logic [15:0] dpin;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic step = 1'b1;

    always #5 clk = ~clk;

    datapath_ctrl_if dp_if ();

    datapath_ctrl dut (
        .clk   (clk),
        .reset (reset),
`ifdef DATAPATH_CTRL_STEP_EN
        .step  (step),
`endif
        .ctrl  (dp_if.slave)
    );

    int   errors = 0;
    int   checks = 0;
    vec_t exp_q[$];
    vec_t pending[$];
    logic [7:0] icount_m = '0;
    logic       err_m    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    function automatic vec_t sample();
        vec_t s;
        s.busy     = dp_if.busy;
        s.done     = dp_if.done;
        s.err      = dp_if.err;
        s.icount   = dp_if.icount;
        s.readnum  = dp_if.readnum;
        s.writenum = dp_if.writenum;
        s.loada    = dp_if.loada;
        s.loadb    = dp_if.loadb;
        s.loadc    = dp_if.loadc;
        s.loads    = dp_if.loads;
        s.write    = dp_if.write;
        s.vsel     = dp_if.vsel;
        s.asel     = dp_if.asel;
        s.bsel     = dp_if.bsel;
        s.shift    = dp_if.shift;
        s.alu      = dp_if.ALUop;
        s.dpin     = dp_if.datapath_in;
        return s;
    endfunction

    // Monitor: compare whatever the model predicted for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            check("outputs", 64'(sample()), 64'(e));
        end
    end

    function automatic vec_t idle_vec();
        vec_t v = '0;
        v.icount = icount_m;
        v.err    = err_m;
        return v;
    endfunction

    // Reference model: expand one accepted instruction into its busy-cycle outputs.
    task automatic accept(input logic [15:0] ins);
        logic [2:0] opc = ins[15:13];
        logic [1:0] op  = ins[12:11];
        logic [2:0] rn  = ins[10:8];
        logic [2:0] rd  = ins[7:5];
        logic [1:0] sh  = ins[4:3];
        logic [2:0] rm  = ins[2:0];
        logic       movi = (opc == 3'b110) && (op == 2'b10);
        logic       mov  = (opc == 3'b110) && (op == 2'b00);
        logic       alu3 = (opc == 3'b101);
        logic       cmp  = alu3 && (op == 2'b01);
        logic       mvn  = alu3 && (op == 2'b11);
        vec_t base, v;
        err_m = !(movi || mov || alu3);
        base = '0;
        base.busy = 1'b1;
        base.err = err_m;
        base.icount = icount_m;
        if (movi) begin
            v = base; v.writenum = rn; v.write = 1'b1; v.vsel = 1'b1;
            v.dpin = 16'($signed(ins[7:0]));
            pending.push_back(v);
        end else if (mov || alu3) begin
            if (!(mov || mvn)) begin
                v = base; v.readnum = rn; v.loada = 1'b1;
                pending.push_back(v);
            end
            v = base; v.readnum = rm; v.loadb = 1'b1;
            pending.push_back(v);
            v = base; v.shift = sh;
            v.alu   = mov ? 2'b00 : op;
            v.asel  = mov || mvn;
            v.loadc = !cmp;
            v.loads = cmp;
            pending.push_back(v);
            if (!cmp) begin
                v = base; v.writenum = rd; v.write = 1'b1;
                pending.push_back(v);
            end
        end
        v = base; v.done = 1'b1;
        pending.push_back(v);
    endtask

    // One clock slot: drive inputs just after the edge and predict this cycle's outputs.
    task automatic cycle(input logic s, input logic [15:0] ins, input logic rst_v, input logic stp);
        vec_t v;
        @(posedge clk);
        #1;
        reset = rst_v;
        dp_if.start = s;
        dp_if.instr = ins;
        step = stp;
        if (rst_v) begin
            pending.delete();
            icount_m = '0;
            err_m = 1'b0;
            v = idle_vec();
        end else if (pending.size() == 0) begin
            v = idle_vec();
            if (s) accept(ins);
        end else begin
            v = pending[0];
`ifdef DATAPATH_CTRL_STEP_EN
            if (stp) begin
`else
            begin
`endif
                void'(pending.pop_front());
                if (v.done && !v.err) icount_m = icount_m + 8'd1;
            end
        end
        exp_q.push_back(v);
    endtask

    task automatic run_instr(input logic [15:0] ins);
        cycle(1'b1, ins, 1'b0, 1'b1);
        while (pending.size() > 0) cycle(1'b0, 16'($urandom), 1'b0, 1'b1);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(0, 6))
            0: r[15:11] = 5'b110_10;
            1: r[15:11] = 5'b110_00;
            2, 3, 4, 5: r[15:13] = 3'b101;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        dp_if.start = 1'b0;
        dp_if.instr = '0;
        repeat (2) @(posedge clk);
        cycle(1'b0, 16'h0, 1'b1, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);

        run_instr(16'hD3FB);
        run_instr(16'hA148);
        run_instr(16'hA900);
        run_instr(16'h0000);
        run_instr(16'hA148);
        run_instr(16'hDF80);
        run_instr(16'hD87F);
        run_instr(16'hC0B1);
        run_instr(16'hBC5A);
        run_instr(16'hB0E6);

        // start held high across two ADDs; reset lands in the second one's LOADB cycle
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'hA148, 1'b0, 1'b1);
        cycle(1'b1, 16'hA148, 1'b1, 1'b1);
        cycle(1'b0, 16'hA148, 1'b1, 1'b1);
        cycle(1'b0, 16'hA148, 1'b0, 1'b1);

`ifdef DATAPATH_CTRL_STEP_EN
        cycle(1'b1, 16'hC022, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b1);
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
        end
`endif

        // icount wrap: 260 back-to-back MOV-imm instructions
        for (int i = 0; i < 260; i++) run_instr({5'b110_10, 11'($urandom)});

        for (int i = 0; i < 1500; i++) begin
            logic stp;
            logic rst_v;
            stp = 1'b1;
`ifdef DATAPATH_CTRL_STEP_EN
            stp = ($urandom_range(0, 2) != 0);
`endif
            rst_v = ($urandom_range(0, 199) == 0);
            cycle(($urandom_range(0, 3) != 0), rand_instr(), rst_v, stp);
        end
        while (pending.size() > 0) cycle(1'b0, 16'($urandom), 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
